// File: rtl/lcd1602_pkg.sv
// Shared types, LCD command constants, static text and hex helper for the
// LCD1602 controller. LCD_CURSOR_BLINK_EN selects the cursor/blink init command.
package lcd1602_pkg;

  typedef enum logic [3:0] {
    IDLE,
    INIT_CMD,
    WR_LINE1,
    SET_LINE2,
    WR_LINE2,
    WAIT_DYN,
    SET_DYN_ADDR,
    WR_DYN_HI,
    WR_DYN_LO
  } lcd_state_e;

  localparam int unsigned IDX_W = 6;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
`ifdef LCD_CURSOR_BLINK_EN
  localparam logic [7:0] CMD_DISPLAY  = 8'h0F;
`else
  localparam logic [7:0] CMD_DISPLAY  = 8'h0C;
`endif
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;
  localparam logic [7:0] CMD_DYN_ADDR = 8'hCE;

  // Index 0 is the first character of line 1, index 16 the first of line 2.
  localparam logic [0:31][7:0] TEXT_ROM = {"DHT11 READING   ", "VALUE:        --"};

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    logic [7:0] c;
    case (i)
      2'd0:    c = CMD_FUNC_SET;
      2'd1:    c = CMD_DISPLAY;
      2'd2:    c = CMD_CLEAR;
      default: c = CMD_ENTRY;
    endcase
    return c;
  endfunction

  // 0-9 -> '0'..'9', 10-15 -> 'A'..'F' (0x41 + n - 10 == 0x37 + n).
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/lcd1602_tick_gen.sv
// Free-running 0..COUNT_MAX-1 counter producing a one-clock timing tick.
module lcd1602_tick_gen #(
  parameter int unsigned COUNT_MAX = 800000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1;

  logic [CW-1:0] count_q, count_d;

  assign tick = (count_q == CW'(COUNT_MAX - 1));

  always_comb begin
    count_d = tick ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/lcd1602_controller.sv
// LCD1602 controller: init commands, two static text lines, then refreshes a
// sampled byte as two hex digits. LCD_CURSOR_BLINK_EN (see lcd1602_pkg)
// selects the cursor/blink display-on command.
module lcd1602_controller
  import lcd1602_pkg::*;
#(
  parameter int unsigned NUM_COMMANDS     = 4,
  parameter int unsigned NUM_DATA_ALL     = 32,
  parameter int unsigned NUM_DATA_PERLINE = 16,
  parameter int unsigned NUM_INPUT_DATA   = 1,
  parameter int unsigned COUNT_MAX        = 800000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ready_i,
  input  logic [7:0] input_data1,
  output logic       rs,
  output logic       rw,
  output logic       enable,
  output logic       ready2wr,
  output logic [7:0] data
);

  if (NUM_INPUT_DATA != 1) begin : g_bad_input_count
    $error("lcd1602_controller supports NUM_INPUT_DATA == 1 only");
  end

  logic tick;

  lcd1602_tick_gen #(.COUNT_MAX(COUNT_MAX)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  lcd_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             phase_q, phase_d;
  logic [7:0]       sampled_q, sampled_d;
  logic             rs_q, rs_d;
  logic             en_q, en_d;
  logic             r2w_q, r2w_d;
  logic [7:0]       data_q, data_d;

  // Per-state write content, completion condition and successor.
  logic             wr_rs, wr_last;
  logic [7:0]       wr_data;
  lcd_state_e       wr_next;
  logic [IDX_W-1:0] wr_next_idx;

  always_comb begin
    wr_rs       = 1'b0;
    wr_data     = '0;
    wr_last     = 1'b1;
    wr_next     = state_q;
    wr_next_idx = '0;
    case (state_q)
      INIT_CMD: begin
        wr_data = init_cmd(idx_q[1:0]);
        wr_last = (idx_q == IDX_W'(NUM_COMMANDS - 1));
        wr_next = WR_LINE1;
      end
      WR_LINE1: begin
        wr_rs   = 1'b1;
        wr_data = TEXT_ROM[idx_q[4:0]];
        wr_last = (idx_q == IDX_W'(NUM_DATA_PERLINE - 1));
        wr_next = SET_LINE2;
      end
      SET_LINE2: begin
        wr_data     = CMD_LINE2;
        wr_next     = WR_LINE2;
        wr_next_idx = IDX_W'(NUM_DATA_PERLINE);
      end
      WR_LINE2: begin
        wr_rs   = 1'b1;
        wr_data = TEXT_ROM[idx_q[4:0]];
        wr_last = (idx_q == IDX_W'(NUM_DATA_ALL - 1));
        wr_next = WAIT_DYN;
      end
      SET_DYN_ADDR: begin
        wr_data = CMD_DYN_ADDR;
        wr_next = WR_DYN_HI;
      end
      WR_DYN_HI: begin
        wr_rs   = 1'b1;
        wr_data = hex_ascii(sampled_q[7:4]);
        wr_next = WR_DYN_LO;
      end
      WR_DYN_LO: begin
        wr_rs   = 1'b1;
        wr_data = hex_ascii(sampled_q[3:0]);
        wr_next = WAIT_DYN;
      end
      default: ;
    endcase
  end

  // Tick-paced sequencing; each write is an enable-high tick then an enable-low tick.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    phase_d   = phase_q;
    sampled_d = sampled_q;
    rs_d      = rs_q;
    en_d      = en_q;
    r2w_d     = r2w_q;
    data_d    = data_q;
    if (tick) begin
      case (state_q)
        IDLE: begin
          state_d = INIT_CMD;
          idx_d   = '0;
          phase_d = 1'b0;
        end
        WAIT_DYN: begin
          r2w_d = 1'b1;
          if (ready_i) begin
            sampled_d = input_data1;
            r2w_d     = 1'b0;
            state_d   = SET_DYN_ADDR;
            phase_d   = 1'b0;
          end
        end
        default: begin
          if (!phase_q) begin
            rs_d    = wr_rs;
            data_d  = wr_data;
            en_d    = 1'b1;
            phase_d = 1'b1;
          end else begin
            en_d    = 1'b0;
            phase_d = 1'b0;
            if (wr_last) begin
              state_d = wr_next;
              idx_d   = wr_next_idx;
              r2w_d   = (wr_next == WAIT_DYN);
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      phase_q   <= 1'b0;
      sampled_q <= '0;
      rs_q      <= 1'b0;
      en_q      <= 1'b0;
      r2w_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      phase_q   <= phase_d;
      sampled_q <= sampled_d;
      rs_q      <= rs_d;
      en_q      <= en_d;
      r2w_q     <= r2w_d;
      data_q    <= data_d;
    end
  end

  assign rs       = rs_q;
  assign rw       = 1'b0;
  assign enable   = en_q;
  assign ready2wr = r2w_q;
  assign data     = data_q;

endmodule

// File: tb/tb_lcd1602_controller.sv
// Scoreboard bench: expected {rs,data} writes are queued when stimulus is
// applied and compared on each enable falling edge.
module tb_lcd1602_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ready_i = 1'b0;
  logic [7:0] input_data1 = '0;
  logic       rs, rw, enable, ready2wr;
  logic [7:0] data;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  logic [8:0]  exp_q[$];
  logic        en_prev = 1'b0;

  always #5 clk = ~clk;

  lcd1602_controller #(
    .NUM_COMMANDS     (4),
    .NUM_DATA_ALL     (32),
    .NUM_DATA_PERLINE (16),
    .NUM_INPUT_DATA   (1),
    .COUNT_MAX        (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ready_i     (ready_i),
    .input_data1 (input_data1),
    .rs          (rs),
    .rw          (rw),
    .enable      (enable),
    .ready2wr    (ready2wr),
    .data        (data)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Writes aborted by reset are ignored; every other falling edge must match.
  always @(negedge clk) begin
    if (en_prev && !enable && !reset) begin
      if (exp_q.size() == 0) check_eq("unexpected_write", {23'd0, rs, data}, 32'h1FF);
      else check_eq("write", {23'd0, rs, data}, {23'd0, exp_q.pop_front()});
    end
    en_prev <= enable;
  end

  task automatic push_static();
    logic [127:0] l1;
    logic [127:0] l2;
    logic [7:0]   cmds [4];
    l1 = "DHT11 READING   ";
    l2 = "VALUE:        --";
    cmds = '{8'h38, 8'h0C, 8'h01, 8'h06};
    foreach (cmds[i]) exp_q.push_back({1'b0, cmds[i]});
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, l1[8*(15-i) +: 8]});
    exp_q.push_back({1'b0, 8'hC0});
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, l2[8*(15-i) +: 8]});
  endtask

  task automatic wait_r2w(input logic val, input string tag);
    for (int i = 0; i < 2000 && ready2wr !== val; i++) @(negedge clk);
    check_eq(tag, {31'd0, ready2wr}, {31'd0, val});
  endtask

  task automatic refresh(input logic [7:0] val, input logic [7:0] hi, input logic [7:0] lo,
                         input bit change_after, input string tag);
    exp_q.push_back({1'b0, 8'hCE});
    exp_q.push_back({1'b1, hi});
    exp_q.push_back({1'b1, lo});
    input_data1 = val;
    ready_i = 1'b1;
    wait_r2w(1'b0, {tag, "_sampled"});
    ready_i = 1'b0;
    if (change_after) begin
      repeat (4) @(negedge clk);
      input_data1 = 8'hFF;
    end
    wait_r2w(1'b1, {tag, "_done"});
    repeat (2) @(negedge clk);
    check_eq({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rs"}, {31'd0, rs}, 0);
    check_eq({tag, "_enable"}, {31'd0, enable}, 0);
    check_eq({tag, "_data"}, {24'd0, data}, 0);
    check_eq({tag, "_ready2wr"}, {31'd0, ready2wr}, 0);
  endtask

  initial begin
    int unsigned cyc;
    int unsigned en_hits;
    int unsigned r2w_low;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check_eq("rw_reset", {31'd0, rw}, 0);

    push_static();
    reset = 1'b0;
    cyc = 0;
    while (enable !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("first_enable_cycle", cyc, 8);

    wait_r2w(1'b1, "static_done");
    repeat (2) @(negedge clk);
    check_eq("static_queue_empty", exp_q.size(), 0);

    en_hits = 0;
    r2w_low = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (enable) en_hits++;
      if (!ready2wr) r2w_low++;
    end
    check_eq("idle_enable_pulses", en_hits, 0);
    check_eq("idle_ready2wr_low", r2w_low, 0);

    refresh(8'h3A, 8'h33, 8'h41, 1'b0, "dyn_3a");
    refresh(8'h09, 8'h30, 8'h39, 1'b1, "dyn_09");
    refresh(8'hFF, 8'h46, 8'h46, 1'b0, "dyn_ff");
    check_eq("rw_run", {31'd0, rw}, 0);

    // Restart and abort in the middle of line 2.
    reset = 1'b1;
    @(negedge clk);
    exp_q.delete();
    push_static();
    reset = 1'b0;
    for (int i = 0; i < 2000 && exp_q.size() > 8; i++) @(negedge clk);
    check_eq("reached_line2", exp_q.size(), 8);
    for (int i = 0; i < 20 && enable !== 1'b1; i++) @(negedge clk);
    check_eq("mid_write_enable", {31'd0, enable}, 1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    @(negedge clk);
    exp_q.delete();
    push_static();
    reset = 1'b0;
    wait_r2w(1'b1, "restart_done");
    repeat (2) @(negedge clk);
    check_eq("restart_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd1602_controller.md
LCD1602_CONTROLLER -- requirements
Module: lcd1602_controller

Interface
REQ-001 SHALL have parameter NUM_COMMANDS, default 4: number of init commands sent after reset.
REQ-002 SHALL have parameter NUM_DATA_ALL, default 32: number of static text characters (both lines).
REQ-003 SHALL have parameter NUM_DATA_PERLINE, default 16: characters per display line.
REQ-004 SHALL have parameter NUM_INPUT_DATA, default 1: number of dynamic input bytes displayed (only 1 supported; input_data1).
REQ-005 SHALL have parameter COUNT_MAX, default 800000: system clocks per LCD timing tick.
REQ-006 SHALL have ports:
  clk  input  1  system clock; one clock domain
  reset  input  1  synchronous, active-high reset
  ready_i  input  1  permits a dynamic-value refresh cycle when high
  input_data1  input  8  byte shown on display as two hex ASCII digits
  rs  output  1  LCD register select (0 = command, 1 = data)
  rw  output  1  LCD read/write; constant 0
  enable  output  1  LCD E strobe
  ready2wr  output  1  high while waiting in the refresh-idle state
  data  output  8  LCD DB7..DB0

Function
REQ-007 SHALL count 0..COUNT_MAX-1 and assert an internal one-clock tick when the count equals COUNT_MAX-1, then wrap to 0; all LCD activity advances only on ticks.
REQ-008 SHALL issue each LCD write over 2 ticks: tick 1 drives rs/data and sets enable=1; tick 2 sets enable=0 with rs/data held (falling edge latches).
REQ-009 FSM states: IDLE, INIT_CMD, WR_LINE1, SET_LINE2, WR_LINE2, WAIT_DYN, SET_DYN_ADDR, WR_DYN_HI, WR_DYN_LO.
REQ-010 IDLE -> INIT_CMD on first tick after reset; INIT_CMD sends commands 0x38, 0x0C, 0x01, 0x06 in order (NUM_COMMANDS entries), rs=0.
REQ-011 WR_LINE1 writes static characters 0..NUM_DATA_PERLINE-1 with rs=1; SET_LINE2 sends command 0xC0; WR_LINE2 writes characters NUM_DATA_PERLINE..NUM_DATA_ALL-1.
REQ-012 Static text: line 1 "DHT11 READING   ", line 2 "VALUE:        --" (16 chars each, space-padded).
REQ-013 WAIT_DYN: ready2wr=1; on a tick with ready_i=1, sample input_data1 into an internal register, ready2wr=0, go to SET_DYN_ADDR; with ready_i=0, stay.
REQ-014 SET_DYN_ADDR sends command 0xCE (line 2, column 14); WR_DYN_HI writes ASCII hex of sampled[7:4]; WR_DYN_LO writes ASCII hex of sampled[3:0]; then return to WAIT_DYN.
REQ-015 Hex-to-ASCII: nibble 0-9 -> 0x30+n; nibble 10-15 -> 0x41+(n-10) (uppercase).
REQ-016 Changes of input_data1 after sampling SHALL NOT affect the ongoing refresh.
REQ-017 rw SHALL be 0 at all times.

Reset
REQ-018 On reset=1 at a clk edge: FSM=IDLE, tick counter=0, all character/command indices=0, sampled register=0, rs=0, enable=0, data=0x00, ready2wr=0.
REQ-019 Reset mid-write SHALL abort immediately (enable=0 next clock) and restart the full init sequence after release.

Configuration
REQ-020 Macro LCD_CURSOR_BLINK_EN: when defined, the second init command SHALL be 0x0F (display on, cursor on, blink on); when undefined, 0x0C (display on, cursor and blink off).

Structure
REQ-021 Shared package lcd1602_pkg SHALL hold the FSM state enumeration, command constants (0x38, 0x0C/0x0F, 0x01, 0x06, 0xC0, 0xCE) and the 32-byte static text table.
REQ-022 One sub-module lcd1602_tick_gen (COUNT_MAX counter, tick output) is natural; the hex-to-ASCII conversion SHALL be a function in the package.

Verification
REQ-023 COUNT_MAX=4, reset for 3 clocks -> all outputs 0, ready2wr=0; first tick after release begins INIT_CMD.
REQ-024 Capture on enable falling edges -> commands 0x38,0x0C,0x01,0x06, 16 line-1 characters, 0xC0, 16 line-2 characters, in order, rs correct for each.
REQ-025 After static text, ready_i=0 -> ready2wr stays 1, no enable pulses for 50 ticks.
REQ-026 input_data1=0x3A, ready_i=1 -> writes 0xCE (rs=0), 0x33 (rs=1), 0x41 (rs=1); ready2wr returns to 1.
REQ-027 input_data1 changed to 0xFF one tick after sampling 0x09 -> displays 0x30, 0x39; next refresh shows 0x46, 0x46.
REQ-028 Reset asserted during line-2 writing -> enable=0 next clock; sequence restarts with 0x38.
